// File: rtl/fmap_stream_tx_pkg.sv
// Shared types for the feature-map transmitter: FSM states and pointer sizing helper.
package fmap_stream_tx_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StClr,
    StStream,
    StLast
  } fmap_state_e;

  function automatic int unsigned addr_bw(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fmap_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port with read enable.
module fmap_sdp_ram #(
  parameter int unsigned Width  = 48,
  parameter int unsigned Depth  = 144,
  parameter int unsigned AddrBw = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [AddrBw-1:0] waddr_i,
  input  logic [Width-1:0]  wdata_i,
  input  logic              re_i,
  input  logic [AddrBw-1:0] raddr_i,
  output logic [Width-1:0]  rdata_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Output register holds its value when no read is issued.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fmap_stream_tx.sv
// Feature-map transmitter: buffers one IF_SIZE x IF_SIZE map of CI-packed pixels and streams
// it in raster order on request, with a leading conv clear and trailing done pulse.
module fmap_stream_tx
  import fmap_stream_tx_pkg::*;
#(
  parameter int unsigned I_BW    = 16,
  parameter int unsigned CI      = 3,
  parameter int unsigned IF_SIZE = 12
) (
  input  logic               clk,
  input  logic               global_rst_n,
  input  logic               i_wr_en,
  input  logic [CI*I_BW-1:0] i_wr_data,
  input  logic               i_clear,
  input  logic               i_start,
  input  logic               i_stall,
  output logic [CI*I_BW-1:0] o_fmap,
  output logic               o_ce,
  output logic               o_rst,
  output logic               o_full,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_wr_err
);

  localparam int unsigned N       = IF_SIZE * IF_SIZE;
  localparam int unsigned W       = CI * I_BW;
  localparam int unsigned ADDR_BW = addr_bw(N);
  // One extra bit so the write pointer can hold N itself.
  localparam int unsigned PTR_BW  = ADDR_BW + 1;

  fmap_state_e        state_q, state_d;
  logic [PTR_BW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_BW-1:0] rd_ptr_q, rd_ptr_d;
  logic               full_q, full_d;
  logic               wr_err_q, wr_err_d;
  logic               done_q, done_d;
  logic               ce_q, ce_d;
  logic               wr_accept;
  logic               rd_en;

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    full_d    = full_q;
    wr_err_d  = wr_err_q;
    done_d    = 1'b0;
    wr_accept = 1'b0;
    rd_en     = 1'b0;

    if (i_clear) begin
      wr_ptr_d = '0;
      full_d   = 1'b0;
      wr_err_d = 1'b0;
      state_d  = StIdle;
    end else begin
      if (i_wr_en) begin
        if (state_q == StIdle && !full_q) begin
          wr_accept = 1'b1;
          wr_ptr_d  = wr_ptr_q + PTR_BW'(1);
          full_d    = (wr_ptr_d == PTR_BW'(N));
        end else begin
          wr_err_d = 1'b1;
        end
      end

      unique case (state_q)
        StIdle: begin
          // full_q is the registered flag, so a write completing the buffer this cycle
          // cannot also launch a frame.
          if (i_start && full_q) begin
            state_d = StClr;
          end
        end
        StClr: begin
          rd_ptr_d = '0;
          state_d  = StStream;
        end
        StStream: begin
          if (!i_stall) begin
            rd_en    = 1'b1;
            rd_ptr_d = rd_ptr_q + ADDR_BW'(1);
            if (rd_ptr_q == ADDR_BW'(N - 1)) begin
              state_d = StLast;
            end
          end
        end
        StLast: begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end

    ce_d = rd_en;
  end

  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      state_q  <= StIdle;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
      wr_err_q <= 1'b0;
      done_q   <= 1'b0;
      ce_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
      wr_err_q <= wr_err_d;
      done_q   <= done_d;
      ce_q     <= ce_d;
    end
  end

  fmap_sdp_ram #(
    .Width (W),
    .Depth (N),
    .AddrBw(ADDR_BW)
  ) u_ram (
    .clk_i  (clk),
    .rst_ni (global_rst_n),
    .we_i   (wr_accept),
    .waddr_i(wr_ptr_q[ADDR_BW-1:0]),
    .wdata_i(i_wr_data),
    .re_i   (rd_en),
    .raddr_i(rd_ptr_q),
    .rdata_o(o_fmap)
  );

  assign o_ce     = ce_q;
  assign o_rst    = (state_q == StClr);
  assign o_full   = full_q;
  assign o_busy   = (state_q != StIdle);
  assign o_done   = done_q;
  assign o_wr_err = wr_err_q;

endmodule
